// File: rtl/map_row_fetcher.sv
// Display-side map RAM reader: prefetches the map row for the next scan line and serves the tile code under the current pixel.
// Optional dot counting per frame is built when DOT_COUNT_EN is defined.
module map_row_fetcher #(
  parameter int RD_LATENCY = 2,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  parameter int TILE_SHIFT = 4
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic [9:0]   hcount,
  input  logic [9:0]   vcount,
  output logic [4:0]   rdaddr,
  input  logic [159:0] rddata,
  output logic [3:0]   tile_code,
  output logic [3:0]   tile_px,
  output logic [3:0]   tile_py,
  output logic         video_on,
  output logic         row_valid,
  output logic         fetch_busy
`ifdef DOT_COUNT_EN
  ,
  output logic [9:0]   dot_count,
  output logic         frame_done
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] LATCH = 2'd3;

  logic [1:0]   state;
  logic [7:0]   wait_cnt;
  logic [9:0]   vcount_q;
  logic [9:0]   hcount_q;
  logic         armed;
  logic         pending;
  logic [159:0] shadow;
  logic [159:0] active;

  logic         line_start;
  logic         commit;
  logic         need;
  logic [9:0]   target;
  logic [4:0]   target_row;
  logic         on;
  logic [9:0]   cx;
  logic [11:0]  cell_shift;

  always_comb begin
    line_start = armed && (vcount != vcount_q);
    target     = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    need       = target < 10'(V_ACTIVE);
    target_row = 5'(target >> TILE_SHIFT);
    commit     = (hcount >= 10'(H_ACTIVE)) && (hcount_q < 10'(H_ACTIVE));
    on         = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
    cx         = hcount >> TILE_SHIFT;
    // Cell 0 sits in the top nibble, so cell cx is 156-4*cx bits up from bit 0.
    cell_shift = 12'd156 - {cx, 2'b00};
  end

  assign fetch_busy = (state != IDLE);

  // Fetch FSM and shadow/active row buffers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rdaddr    <= '0;
      vcount_q  <= '0;
      hcount_q  <= '0;
      armed     <= 1'b0;
      pending   <= 1'b0;
      row_valid <= 1'b0;
      shadow    <= '0;
      active    <= '0;
    end else begin
      vcount_q <= vcount;
      hcount_q <= hcount;
      armed    <= 1'b1;
      if (commit) begin
        if (pending) begin
          active    <= shadow;
          pending   <= 1'b0;
          row_valid <= 1'b1;
        end else begin
          row_valid <= 1'b0;
        end
      end
      // A latch landing on the commit cycle keeps the new row pending for the next line.
      case (state)
        IDLE: begin
          if (line_start && need) begin
            rdaddr <= target_row;
            state  <= REQ;
          end
        end
        REQ: begin
          wait_cnt <= 8'd1;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (wait_cnt == 8'(RD_LATENCY)) state <= LATCH;
        end
        LATCH: begin
          shadow  <= rddata;
          pending <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel stage: outputs aligned one cycle after hcount/vcount
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tile_code <= '0;
      tile_px   <= '0;
      tile_py   <= '0;
      video_on  <= 1'b0;
    end else begin
      tile_code <= on ? 4'(active >> cell_shift) : 4'd0;
      tile_px   <= hcount[3:0];
      tile_py   <= vcount[3:0];
      video_on  <= on;
    end
  end

`ifdef DOT_COUNT_EN
  logic [9:0] dot_acc;
  logic       first_line;

  function automatic logic [5:0] count_dots(input logic [159:0] row);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 40; i++) begin
      if (row[4*i +: 4] == 4'd1) n = n + 6'd1;
    end
    return n;
  endfunction

  // Only the first line of each tile row contributes, so every row counts once per frame.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      first_line <= 1'b0;
      dot_acc    <= '0;
      dot_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE && line_start && need) first_line <= (target[3:0] == 4'd0);
      if (state == LATCH && first_line) begin
        if (rdaddr == 5'd29) begin
          dot_count  <= dot_acc + 10'(count_dots(rddata));
          dot_acc    <= '0;
          frame_done <= 1'b1;
        end else begin
          dot_acc <= dot_acc + 10'(count_dots(rddata));
        end
      end
    end
  end
`endif

endmodule
